audio_sequencer: RTL and testbench

AUDIO_SEQUENCER -- requirements
Module: audio_sequencer

---
 rtl/audio_seq_pkg.sv | 16 +
 rtl/audio_note_fifo.sv | 51 +++++
 rtl/audio_sequencer.sv | 159 +++++++++++++++
 tb/tb_audio_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_seq_pkg.sv
// Shared definitions for the audio note sequencer: FSM states, parameter
// defaults and counter sizing helper.
package audio_seq_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, PLAY, GAP, DONE} state_t;

  localparam int TICK_CYCLES_DEF = 50000;
  localparam int PITCH_UNIT_DEF  = 64;
  localparam int DEPTH_DEF       = 4;

  // Bits needed for a counter that runs 0 .. n-1.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/audio_note_fifo.sv
// First-word-fall-through note queue; a push while full is accepted only
// when a pop frees the slot in the same cycle.
module audio_note_fifo
  import audio_seq_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        full,
  output logic        empty,
  output logic        last
);

  localparam int AW = $clog2(DEPTH);

  logic [15:0] mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] fill;
  logic        wr_en;
  logic        rd_en;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fill  = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign last  = (fill == (AW+1)'(1));
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/audio_sequencer.sv
// Plays queued {pitch, duration} notes as a square wave, inserting a one-tick
// gap after each note and pulsing cont once the queue has drained.
module audio_sequencer
  import audio_seq_pkg::*;
#(
  parameter int TICK_CYCLES = TICK_CYCLES_DEF,
  parameter int PITCH_UNIT  = PITCH_UNIT_DEF,
  parameter int DEPTH       = DEPTH_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] note_pitch,
  input  logic [7:0] note_dur,
  input  logic       tempo_we,
  input  logic       play,
  output logic       speaker,
  output logic       cont,
  output logic       busy,
  output logic       full,
  output logic       empty,
  output logic       overflow
);

  localparam int TW = cnt_w(TICK_CYCLES);
  localparam int PW = cnt_w(255 * PITCH_UNIT);

  state_t        state;
  logic [15:0]   head;
  logic          pop;
  logic          last;
  logic          more;
  logic [7:0]    pitch_r;
  logic [7:0]    dur_r;
  logic [7:0]    tempo;
  logic [7:0]    tempo_cur;
  logic [7:0]    tempo_cnt;
  logic [7:0]    dur_cnt;
  logic [TW-1:0] tick_cnt;
  logic [PW-1:0] phase_cnt;
  logic [PW-1:0] half_period;
  logic          tick_end;
  logic          play_end;

  audio_note_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   ({note_pitch, note_dur}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .last  (last)
  );

  assign pop         = (state == LOAD);
  // After this LOAD's pop the queue still holds a note, or one arrives now.
  assign more        = !last || push;
  assign half_period = PW'(pitch_r) * PW'(PITCH_UNIT);
  assign tick_end    = (tick_cnt == TW'(TICK_CYCLES - 1));
  assign play_end    = tick_end && (tempo_cnt == tempo_cur) && (dur_cnt == dur_r - 8'd1);

  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      pitch_r   <= head[15:8];
      dur_r     <= head[7:0];
      tempo_cur <= tempo;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      speaker   <= 1'b0;
      cont      <= 1'b0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
      tempo     <= '0;
      tick_cnt  <= '0;
      tempo_cnt <= '0;
      dur_cnt   <= '0;
      phase_cnt <= '0;
    end else begin
      if (tempo_we) tempo <= note_pitch;
      if (push && full && !pop) overflow <= 1'b1;
      case (state)
        IDLE: begin
          if (play) begin
            busy  <= 1'b1;
            state <= empty ? DONE : LOAD;
            cont  <= empty;
          end
        end
        LOAD: begin
          tick_cnt  <= '0;
          tempo_cnt <= '0;
          dur_cnt   <= '0;
          phase_cnt <= '0;
          if (head[7:0] == 8'd0) begin
            state <= more ? LOAD : DONE;
            cont  <= !more;
          end else begin
            state   <= PLAY;
            speaker <= (head[15:8] != 8'd0);
          end
        end
        PLAY: begin
          if (play_end) begin
            state    <= GAP;
            speaker  <= 1'b0;
            tick_cnt <= '0;
          end else begin
            if (tick_end) begin
              tick_cnt <= '0;
              if (tempo_cnt == tempo_cur) begin
                tempo_cnt <= '0;
                dur_cnt   <= dur_cnt + 8'd1;
              end else begin
                tempo_cnt <= tempo_cnt + 8'd1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
            if (pitch_r != 8'd0) begin
              if (phase_cnt == half_period - PW'(1)) begin
                phase_cnt <= '0;
                speaker   <= ~speaker;
              end else begin
                phase_cnt <= phase_cnt + 1'b1;
              end
            end
          end
        end
        GAP: begin
          if (tick_end) begin
            tick_cnt <= '0;
            state    <= empty ? DONE : LOAD;
            cont     <= empty;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          cont  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          speaker <= 1'b0;
          cont    <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_audio_sequencer.sv
// Scoreboard bench for audio_sequencer: each run's expected profile is queued
// before play, and a monitor measures the run and compares on the cont pulse.
module tb_audio_sequencer;

  localparam int TICK = 10;
  localparam int PU   = 2;
  localparam int DEP  = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       push;
  logic [7:0] note_pitch;
  logic [7:0] note_dur;
  logic       tempo_we;
  logic       play;
  logic       speaker;
  logic       cont;
  logic       busy;
  logic       full;
  logic       empty;
  logic       overflow;

  always #5 clk = ~clk;

  audio_sequencer #(.TICK_CYCLES(TICK), .PITCH_UNIT(PU), .DEPTH(DEP)) dut (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .note_pitch (note_pitch),
    .note_dur   (note_dur),
    .tempo_we   (tempo_we),
    .play       (play),
    .speaker    (speaker),
    .cont       (cont),
    .busy       (busy),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow)
  );

  typedef struct {
    int busy_cycles;
    int high_cycles;
    int transitions;
    int first_run;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   acc_busy, acc_high, acc_trans, acc_first;
  logic first_done, prev_spk;

  task automatic cmp(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic clear_acc();
    acc_busy   = 0;
    acc_high   = 0;
    acc_trans  = 0;
    acc_first  = 0;
    first_done = 1'b0;
    prev_spk   = 1'b0;
  endtask

  // Monitor: profile each run (busy cycles, speaker high cycles, speaker
  // transitions, first high stretch) and check it when cont appears.
  always @(negedge clk) begin
    if (reset) begin
      clear_acc();
    end else begin
      if (busy) begin
        acc_busy++;
        if (speaker) acc_high++;
        if (speaker != prev_spk) acc_trans++;
        if (speaker && !first_done) acc_first++;
        if (!speaker && acc_first > 0) first_done = 1'b1;
      end
      prev_spk = speaker;
      if (cont) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_cont: cont seen with no run expected");
        end else begin
          mon_e = exp_q.pop_front();
          cmp("busy_cycles", acc_busy, mon_e.busy_cycles);
          cmp("speaker_high_cycles", acc_high, mon_e.high_cycles);
          cmp("speaker_transitions", acc_trans, mon_e.transitions);
          cmp("first_half_period", acc_first, mon_e.first_run);
        end
        clear_acc();
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_note(input int p, input int d);
    push       = 1'b1;
    note_pitch = 8'(p);
    note_dur   = 8'(d);
    tick();
    push = 1'b0;
  endtask

  task automatic set_tempo(input int t);
    tempo_we   = 1'b1;
    note_pitch = 8'(t);
    tick();
    tempo_we = 1'b0;
  endtask

  task automatic expect_run(input int b, input int h, input int t, input int f);
    exp_t e;
    e.busy_cycles = b;
    e.high_cycles = h;
    e.transitions = t;
    e.first_run   = f;
    exp_q.push_back(e);
  endtask

  task automatic play_pulse();
    play = 1'b1;
    tick();
    play = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 1000 && busy; i++) tick();
    cmp("run_completes", int'(busy), 0);
    tick();
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    push       = 1'b0;
    note_pitch = '0;
    note_dur   = '0;
    tempo_we   = 1'b0;
    play       = 1'b0;
    clear_acc();
    tick();
    tick();
    cmp("reset_empty", int'(empty), 1);
    cmp("reset_full", int'(full), 0);
    cmp("reset_overflow", int'(overflow), 0);
    cmp("reset_busy", int'(busy), 0);
    cmp("reset_cont", int'(cont), 0);
    cmp("reset_speaker", int'(speaker), 0);
    reset = 1'b0;
    tick();

    // Empty queue: DONE immediately.
    expect_run(1, 0, 0, 0);
    play_pulse();
    wait_idle();

    // (3,2), tempo 0: LOAD + 20 PLAY + 10 GAP + DONE, half-period 6.
    expect_run(32, 12, 4, 6);
    push_note(3, 2);
    play_pulse();
    wait_idle();

    // Fill, overflow, then four notes play.
    push_note(1, 1);
    push_note(2, 1);
    push_note(1, 1);
    push_note(2, 1);
    cmp("full_after_four", int'(full), 1);
    cmp("overflow_before_fifth", int'(overflow), 0);
    push_note(3, 1);
    cmp("overflow_after_fifth", int'(overflow), 1);
    cmp("full_after_fifth", int'(full), 1);
    expect_run(85, 24, 20, 2);
    play_pulse();
    wait_idle();
    cmp("empty_after_run", int'(empty), 1);

    // Note pushed mid-run joins the same run.
    expect_run(43, 12, 10, 2);
    push_note(1, 1);
    play_pulse();
    repeat (5) tick();
    push_note(2, 1);
    wait_idle();

    // Zero-duration entry is skipped.
    expect_run(23, 6, 4, 4);
    push_note(5, 0);
    push_note(2, 1);
    play_pulse();
    wait_idle();

    // Tempo 1 with a rest: 20 silent PLAY cycles.
    set_tempo(1);
    expect_run(32, 0, 0, 0);
    push_note(0, 1);
    play_pulse();
    wait_idle();

    // Simultaneous push and tempo load: tempo 2, note (2,1) -> 30 PLAY cycles.
    expect_run(42, 16, 8, 4);
    push       = 1'b1;
    tempo_we   = 1'b1;
    note_pitch = 8'd2;
    note_dur   = 8'd1;
    tick();
    push     = 1'b0;
    tempo_we = 1'b0;
    play_pulse();
    wait_idle();

    // Reset mid-note aborts with no cont pulse.
    push_note(3, 2);
    play_pulse();
    repeat (8) tick();
    cmp("busy_midplay", int'(busy), 1);
    reset = 1'b1;
    tick();
    cmp("abort_speaker", int'(speaker), 0);
    cmp("abort_busy", int'(busy), 0);
    cmp("abort_empty", int'(empty), 1);
    cmp("abort_cont", int'(cont), 0);
    cmp("abort_overflow", int'(overflow), 0);
    reset = 1'b0;
    repeat (40) tick();

    cmp("pending_expectations", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
